// File: rtl/icache_def.sv
// Shared definitions for the memory responder: request bundle, FSM states
// and default timing constants.
package icache_def;

  localparam int unsigned MEM_LATENCY_DEFAULT = 4;
  localparam int unsigned CNT_W               = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;     // 1 = write
    logic        valid;
  } mem_req_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Word-wide storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module mem_array #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Two-port (instruction/data) memory responder with fixed latency and
// round-robin arbitration between simultaneous requests.
module mem_responder
  import icache_def::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_req_type i_req,
  input  mem_req_type d_req,
  output logic [15:0] i_data,
  output logic        i_rdy,
  output logic [15:0] d_data,
  output logic        d_rdy
);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rr_prefer_d_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [15:0]       cap_data_q;
  logic              cap_rw_q;
  logic              cap_is_d_q;
  logic [15:0]       i_data_q, d_data_q;
  logic [15:0]       mem_rdata;
  logic              mem_we;
  logic              accept, grant_d;

  // Upper address bits alias onto the decoded range by design.
  logic [2*(16-ADDR_W)-1:0] req_addr_hi_unused;
  assign req_addr_hi_unused = {i_req.addr[15:ADDR_W], d_req.addr[15:ADDR_W]};

  assign accept  = (state_q == ST_IDLE) && (i_req.valid || d_req.valid);
  assign grant_d = d_req.valid && (!i_req.valid || rr_prefer_d_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (MEM_LATENCY <= 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      rr_prefer_d_q <= 1'b1;
      cap_addr_q    <= '0;
      cap_data_q    <= '0;
      cap_rw_q      <= 1'b0;
      cap_is_d_q    <= 1'b0;
      i_data_q      <= '0;
      d_data_q      <= '0;
    end else begin
      if (accept) begin
        cap_is_d_q    <= grant_d;
        rr_prefer_d_q <= !grant_d;
        cap_addr_q    <= grant_d ? d_req.addr[ADDR_W-1:0] : i_req.addr[ADDR_W-1:0];
        cap_data_q    <= grant_d ? d_req.data : i_req.data;
        cap_rw_q      <= grant_d ? d_req.rw : i_req.rw;
        cnt_q         <= CNT_W'(MEM_LATENCY - 1);
      end else if (state_q == ST_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Read data is shown combinationally during RESP and latched here to hold.
      if (state_q == ST_RESP && !cap_rw_q) begin
        if (cap_is_d_q) d_data_q <= mem_rdata;
        else            i_data_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    i_rdy  = (state_q == ST_RESP) && !rst && !cap_is_d_q;
    d_rdy  = (state_q == ST_RESP) && !rst &&  cap_is_d_q;
    mem_we = (state_q == ST_RESP) && !rst &&  cap_rw_q;
    i_data = (state_q == ST_RESP && !cap_rw_q && !cap_is_d_q) ? mem_rdata : i_data_q;
    d_data = (state_q == ST_RESP && !cap_rw_q &&  cap_is_d_q) ? mem_rdata : d_data_q;
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cap_addr_q),
    .wdata (cap_data_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at latency 4, one at latency 1.
module tb_mem_responder;
  import icache_def::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  mem_req_type i_req0 = '0, d_req0 = '0, i_req1 = '0, d_req1 = '0;
  logic [15:0] i_data0, d_data0, i_data1, d_data1;
  logic        i_rdy0, d_rdy0, i_rdy1, d_rdy1;

  int vecs = 0;
  int errs = 0;

  int          w_i_cyc, w_d_cyc, w_i_cnt, w_d_cnt, w_both;
  logic [15:0] w_i_d, w_d_d;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(12), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req0), .d_req(d_req0),
    .i_data(i_data0), .i_rdy(i_rdy0), .d_data(d_data0), .d_rdy(d_rdy0)
  );

  mem_responder #(.ADDR_W(12), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .i_req(i_req1), .d_req(d_req1),
    .i_data(i_data1), .i_rdy(i_rdy1), .d_data(d_data1), .d_rdy(d_rdy1)
  );

  task automatic drive(input bit inst, input bit is_d, input bit rw,
                       input logic [15:0] addr, input logic [15:0] data);
    mem_req_type r;
    r.addr = addr; r.data = data; r.rw = rw; r.valid = 1'b1;
    case ({inst, is_d})
      2'b00:   i_req0 = r;
      2'b01:   d_req0 = r;
      2'b10:   i_req1 = r;
      default: d_req1 = r;
    endcase
  endtask

  task automatic clear_reqs();
    i_req0 = '0; d_req0 = '0; i_req1 = '0; d_req1 = '0;
  endtask

  // Observe n cycles after acceptance; cycle k is sampled at the negedge following edge k-1.
  task automatic watch(input bit inst, input int n);
    logic ri, rd;
    w_i_cyc = 0; w_d_cyc = 0; w_i_cnt = 0; w_d_cnt = 0; w_both = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ri = inst ? i_rdy1 : i_rdy0;
      rd = inst ? d_rdy1 : d_rdy0;
      if (w_i_cyc == 0) w_i_d = inst ? i_data1 : i_data0;
      if (w_d_cyc == 0) w_d_d = inst ? d_data1 : d_data0;
      if (ri && w_i_cyc == 0) w_i_cyc = k;
      if (rd && w_d_cyc == 0) w_d_cyc = k;
      if (ri) w_i_cnt++;
      if (rd) w_d_cnt++;
      if (ri && rd) w_both++;
    end
  endtask

  task automatic txn(input bit inst, input bit is_d, input bit rw,
                     input logic [15:0] addr, input logic [15:0] data, input int n);
    drive(inst, is_d, rw, addr, data);
    @(posedge clk); #1;
    clear_reqs();
    watch(inst, n);
    @(posedge clk); #1;
  endtask

  task automatic tie_run();
    w_i_cyc = 0; w_d_cyc = 0; w_i_cnt = 0; w_d_cnt = 0; w_both = 0;
    drive(0, 0, 0, 16'h0020, 16'h0000);
    drive(0, 1, 0, 16'h0010, 16'h0000);
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (i_rdy0 && w_i_cyc == 0) begin w_i_cyc = k; w_i_d = i_data0; end
      if (d_rdy0 && w_d_cyc == 0) begin w_d_cyc = k; w_d_d = d_data0; end
      if (i_rdy0) w_i_cnt++;
      if (d_rdy0) w_d_cnt++;
      if (i_rdy0 && d_rdy0) w_both++;
      @(posedge clk); #1;
      if (w_i_cyc != 0) i_req0.valid = 1'b0;
      if (w_d_cyc != 0) d_req0.valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vecs++; if (i_rdy0 !== 1'b0) begin errs++; $display("FAIL reset i_rdy0: got %b want 0", i_rdy0); end
    vecs++; if (d_rdy0 !== 1'b0) begin errs++; $display("FAIL reset d_rdy0: got %b want 0", d_rdy0); end
    vecs++; if (i_data0 !== 16'h0000) begin errs++; $display("FAIL reset i_data0: got %h want 0000", i_data0); end
    vecs++; if (d_data0 !== 16'h0000) begin errs++; $display("FAIL reset d_data0: got %h want 0000", d_data0); end
    vecs++; if (i_rdy1 !== 1'b0 || d_rdy1 !== 1'b0) begin errs++; $display("FAIL reset rdy1: got %b%b want 00", i_rdy1, d_rdy1); end
    vecs++; if (i_data1 !== 16'h0000 || d_data1 !== 16'h0000) begin errs++; $display("FAIL reset data1: got %h/%h want 0000/0000", i_data1, d_data1); end
  endtask

  task automatic test_read_latency();
    txn(0, 1, 1, 16'h0010, 16'hBEEF, 4);
    vecs++; if (w_d_cyc !== 4) begin errs++; $display("FAIL preload d_rdy cycle: got %0d want 4", w_d_cyc); end
    txn(0, 1, 0, 16'h0010, 16'h0000, 4);
    vecs++; if (w_d_cyc !== 4) begin errs++; $display("FAIL rd_lat d_rdy cycle: got %0d want 4", w_d_cyc); end
    vecs++; if (w_d_cnt !== 1) begin errs++; $display("FAIL rd_lat d_rdy count: got %0d want 1", w_d_cnt); end
    vecs++; if (w_i_cnt !== 0) begin errs++; $display("FAIL rd_lat i_rdy count: got %0d want 0", w_i_cnt); end
    vecs++; if (w_d_d !== 16'hBEEF) begin errs++; $display("FAIL rd_lat d_data: got %h want beef", w_d_d); end
    vecs++; if (d_data0 !== 16'hBEEF) begin errs++; $display("FAIL rd_lat d_data hold: got %h want beef", d_data0); end
  endtask

  task automatic test_write_then_read();
    txn(0, 1, 1, 16'h0020, 16'h1234, 4);
    vecs++; if (w_d_cyc !== 4) begin errs++; $display("FAIL wr d_rdy cycle: got %0d want 4", w_d_cyc); end
    vecs++; if (w_d_d !== 16'hBEEF) begin errs++; $display("FAIL wr d_data unchanged: got %h want beef", w_d_d); end
    txn(0, 0, 0, 16'h0020, 16'h0000, 4);
    vecs++; if (w_i_cyc !== 4) begin errs++; $display("FAIL wr_rd i_rdy cycle: got %0d want 4", w_i_cyc); end
    vecs++; if (w_d_cnt !== 0) begin errs++; $display("FAIL wr_rd d_rdy count: got %0d want 0", w_d_cnt); end
    vecs++; if (w_i_d !== 16'h1234) begin errs++; $display("FAIL wr_rd i_data: got %h want 1234", w_i_d); end
    vecs++; if (d_data0 !== 16'hBEEF) begin errs++; $display("FAIL wr_rd d_data: got %h want beef", d_data0); end
  endtask

  task automatic test_round_robin();
    tie_run();
    vecs++; if (w_d_cyc !== 4) begin errs++; $display("FAIL rr1 d_rdy cycle: got %0d want 4", w_d_cyc); end
    vecs++; if (w_i_cyc !== 9) begin errs++; $display("FAIL rr1 i_rdy cycle: got %0d want 9", w_i_cyc); end
    vecs++; if (w_i_cnt !== 1 || w_d_cnt !== 1) begin errs++; $display("FAIL rr1 rdy counts: got i%0d d%0d want i1 d1", w_i_cnt, w_d_cnt); end
    vecs++; if (w_both !== 0) begin errs++; $display("FAIL rr1 both rdy: got %0d want 0", w_both); end
    vecs++; if (w_d_d !== 16'hBEEF || w_i_d !== 16'h1234) begin errs++; $display("FAIL rr1 data: got d%h i%h want dbeef i1234", w_d_d, w_i_d); end
    // d served alone leaves i as the preferred side for the next tie
    txn(0, 1, 0, 16'h0010, 16'h0000, 4);
    tie_run();
    vecs++; if (w_i_cyc !== 4) begin errs++; $display("FAIL rr2 i_rdy cycle: got %0d want 4", w_i_cyc); end
    vecs++; if (w_d_cyc !== 9) begin errs++; $display("FAIL rr2 d_rdy cycle: got %0d want 9", w_d_cyc); end
    vecs++; if (w_both !== 0) begin errs++; $display("FAIL rr2 both rdy: got %0d want 0", w_both); end
  endtask

  task automatic test_reset_abort();
    txn(0, 1, 1, 16'h0030, 16'h0A0A, 4);
    drive(0, 1, 1, 16'h0030, 16'h5555);
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    watch(0, 6);
    vecs++; if (w_d_cnt !== 0 || w_i_cnt !== 0) begin errs++; $display("FAIL abort rdy: got i%0d d%0d want 0 0", w_i_cnt, w_d_cnt); end
    vecs++; if (d_data0 !== 16'h0000) begin errs++; $display("FAIL abort d_data cleared: got %h want 0000", d_data0); end
    @(posedge clk); #1;
    txn(0, 1, 0, 16'h0030, 16'h0000, 4);
    vecs++; if (w_d_cyc !== 4) begin errs++; $display("FAIL abort readback cycle: got %0d want 4", w_d_cyc); end
    vecs++; if (w_d_d !== 16'h0A0A) begin errs++; $display("FAIL abort readback data: got %h want 0a0a", w_d_d); end
  endtask

  task automatic test_alias();
    drive(0, 0, 0, 16'hF010, 16'h0000);
    @(posedge clk); #1;
    i_req0.addr = 16'h0020; i_req0.data = 16'hDEAD; i_req0.rw = 1'b1; i_req0.valid = 1'b0;
    watch(0, 4);
    @(posedge clk); #1;
    clear_reqs();
    vecs++; if (w_i_cyc !== 4) begin errs++; $display("FAIL alias i_rdy cycle: got %0d want 4", w_i_cyc); end
    vecs++; if (w_i_d !== 16'hBEEF) begin errs++; $display("FAIL alias i_data: got %h want beef", w_i_d); end
    txn(0, 1, 0, 16'h0020, 16'h0000, 4);
    vecs++; if (w_d_d !== 16'h1234) begin errs++; $display("FAIL alias no stray write: got %h want 1234", w_d_d); end
  endtask

  task automatic test_latency_one();
    logic [15:0] dat [1:4];
    logic        rdy [1:4];
    txn(1, 1, 1, 16'h0001, 16'h1111, 1);
    vecs++; if (w_d_cyc !== 1) begin errs++; $display("FAIL l1 write d_rdy cycle: got %0d want 1", w_d_cyc); end
    txn(1, 1, 1, 16'h0002, 16'h2222, 1);
    drive(1, 0, 0, 16'h0001, 16'h0000);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rdy[k] = i_rdy1; dat[k] = i_data1;
      @(posedge clk); #1;
      if (k == 1) i_req1.addr = 16'h0002;
      if (k == 3) i_req1.valid = 1'b0;
    end
    vecs++; if (rdy[1] !== 1'b1 || dat[1] !== 16'h1111) begin errs++; $display("FAIL l1 cycle1: got rdy %b data %h want 1 1111", rdy[1], dat[1]); end
    vecs++; if (rdy[2] !== 1'b0 || dat[2] !== 16'h1111) begin errs++; $display("FAIL l1 cycle2: got rdy %b data %h want 0 1111", rdy[2], dat[2]); end
    vecs++; if (rdy[3] !== 1'b1 || dat[3] !== 16'h2222) begin errs++; $display("FAIL l1 cycle3: got rdy %b data %h want 1 2222", rdy[3], dat[3]); end
    vecs++; if (rdy[4] !== 1'b0) begin errs++; $display("FAIL l1 cycle4: got rdy %b want 0", rdy[4]); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_round_robin();
    test_reset_abort();
    test_alias();
    test_latency_one();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
